// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC + 1-cycle imem fetch with stall/branch handling; IFU_HALT_ON_ZERO_EN adds halt-on-zero-word
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
`ifdef IFU_HALT_ON_ZERO_EN
  output logic              halted,
`endif
  output logic              instr_valid
);
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic              req_valid_q, req_valid_d, hold, zero_hit;
`ifdef IFU_HALT_ON_ZERO_EN
  logic halted_q, halted_d;
  assign hold     = halted_q;
  assign zero_hit = req_valid_q & ~|imem_data;
  assign halted   = halted_q;
  always_comb halted_d = branch_taken ? 1'b0 : halted_q | (~stall & zero_hit);
  always_ff @(posedge clk) halted_q <= rst ? 1'b0 : halted_d;
`else
  assign hold     = 1'b0;
  assign zero_hit = 1'b0;
`endif
  assign imem_addr   = (hold | ~stall | branch_taken) ? pc_q : req_pc_q;
  assign instr       = imem_data;
  assign instr_pc    = req_pc_q;
  assign instr_valid = req_valid_q & ~branch_taken;
  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    if (branch_taken) begin
      pc_d        = branch_target;
      req_valid_d = 1'b0;
    end else if (!stall && !hold && zero_hit) begin
      req_valid_d = 1'b0;
    end else if (!stall && !hold) begin
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
      pc_d        = pc_q + PC_STEP;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
    end
  end
endmodule
